// File: rtl/fifo_rd_stream.sv
// Read-side drain for a first-word-fall-through FIFO: pops into a 2-entry
// registered skid buffer feeding a valid/ready stream, with pause, flush and statistics.
module fifo_rd_stream #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    input  logic             enable,
    input  logic             flush,
    output logic             m_valid,
    output logic [DSIZE-1:0] m_data,
    input  logic             m_ready,
    output logic             flush_done,
    output logic             busy,
    output logic [CNT_W-1:0] pop_count,
    output logic [CNT_W-1:0] drop_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         occ_q, occ_d;
    logic [DSIZE-1:0]   slot0_q, slot0_d;
    logic [DSIZE-1:0]   slot1_q, slot1_d;
    logic               m_valid_q, m_valid_d;
    logic               flush_done_q, flush_done_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   pop_cnt_q, pop_cnt_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic               xfer;
    logic               push;
    logic [1:0]         occ_mid;

    // Pop strobe depends only on registered state and the FIFO empty flag.
    assign rinc = !rempty && ((state_q == RUN && occ_q != 2'd2) || state_q == FLUSH);

    assign xfer    = m_valid_q && m_ready;
    assign push    = rinc && (state_q == RUN);
    assign occ_mid = occ_q - 2'(xfer);

    always_comb begin
        state_d      = state_q;
        occ_d        = occ_q;
        slot0_d      = slot0_q;
        slot1_d      = slot1_q;
        flush_done_d = 1'b0;
        pop_cnt_d    = pop_cnt_q;
        drop_cnt_d   = drop_cnt_q;

        if (xfer) begin
            pop_cnt_d = pop_cnt_q + CNT_W'(1);
        end

        // Skid buffer: head shifts out on transfer, popped word lands at the new tail.
        if (state_q != FLUSH) begin
            if (xfer) begin
                slot0_d = slot1_q;
            end
            if (push) begin
                if (occ_mid == 2'd0) begin
                    slot0_d = rdata;
                end else begin
                    slot1_d = rdata;
                end
                occ_d = occ_mid + 2'd1;
            end else begin
                occ_d = occ_mid;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = FLUSH;
                end else if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = FLUSH;
                end else if (!enable) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (rinc) begin
                    drop_cnt_d = drop_cnt_q + CNT_W'(1);
                end
                if (rempty) begin
                    flush_done_d = 1'b1;
                    state_d      = enable ? RUN : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush entry discards whatever survives this edge, including a same-edge pop.
        if (flush && state_q != FLUSH) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(occ_mid) + CNT_W'(push);
            occ_d      = 2'd0;
        end
    end

    assign m_valid_d = (occ_d != 2'd0);
    assign busy_d    = (state_d == FLUSH);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q      <= IDLE;
            occ_q        <= 2'd0;
            slot0_q      <= '0;
            slot1_q      <= '0;
            m_valid_q    <= 1'b0;
            flush_done_q <= 1'b0;
            busy_q       <= 1'b0;
            pop_cnt_q    <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            occ_q        <= occ_d;
            slot0_q      <= slot0_d;
            slot1_q      <= slot1_d;
            m_valid_q    <= m_valid_d;
            flush_done_q <= flush_done_d;
            busy_q       <= busy_d;
            pop_cnt_q    <= pop_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = slot0_q;
    assign flush_done = flush_done_q;
    assign busy       = busy_q;
    assign pop_count  = pop_cnt_q;
    assign drop_count = drop_cnt_q;

endmodule
